// File: rtl/clink_mvm_seq.sv
// Per-gate MVM issue sequencer for a recurrent cell: walks gates within each
// timestep, handshakes every MVM request and strobes cell update / recurrence start.
module clink_mvm_seq #(
  parameter int NUM_GATES = 4,
  parameter int TANH_GATE = 1,
  parameter int ADDR_W    = 5,
  parameter int STEP_W    = 3,
  localparam int GATE_W   = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic [STEP_W-1:0] num_steps_i,
  input  logic [ADDR_W-1:0] weight_base_i,
  input  logic              abort_i,
  input  logic              mvm_ready_i,
  output logic              mvm_valid_o,
  output logic              mvm_isTanh_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic [GATE_W-1:0] gate_idx_o,
  output logic [STEP_W-1:0] step_idx_o,
  output logic              cell_update_o,
  output logic              rec_start_o,
  output logic              busy_o,
  output logic              done_o
);

  // state   | meaning
  // IDLE    | waiting for an accepted start, all outputs low
  // ISSUE   | presenting one gate MVM request, waiting for ready
  // CELL    | one-cycle cell-state update after the last gate of a step
  // DONE    | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CELL  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [GATE_W-1:0] LAST_GATE = GATE_W'(NUM_GATES - 1);
  localparam logic [GATE_W-1:0] TANH_IDX  = GATE_W'(TANH_GATE);
  localparam bit                TANH_EN   = (TANH_GATE >= 0) && (TANH_GATE < NUM_GATES);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   nsteps_q, nsteps_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic                valid_q, valid_d;
  logic                tanh_q, tanh_d;
  logic                cell_q, cell_d;
  logic                rec_q, rec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                handshake;
  logic                last_step;

  assign handshake = valid_q & mvm_ready_i;
  assign last_step = (step_q == (nsteps_q - STEP_W'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      nsteps_q <= '0;
      addr_q   <= '0;
      gate_q   <= '0;
      step_q   <= '0;
      valid_q  <= 1'b0;
      tanh_q   <= 1'b0;
      cell_q   <= 1'b0;
      rec_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nsteps_q <= nsteps_d;
      addr_q   <= addr_d;
      gate_q   <= gate_d;
      step_q   <= step_d;
      valid_q  <= valid_d;
      tanh_q   <= tanh_d;
      cell_q   <= cell_d;
      rec_q    <= rec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    nsteps_d = nsteps_q;
    addr_d   = addr_q;
    gate_d   = gate_q;
    step_d   = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && (num_steps_i != '0) && !abort_i) begin
          state_d  = S_ISSUE;
          nsteps_d = num_steps_i;
          addr_d   = weight_base_i;
          gate_d   = '0;
          step_d   = '0;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          addr_d = addr_q + ADDR_W'(1);
          if (gate_q == LAST_GATE) begin
            state_d = S_CELL;
          end else begin
            gate_d = gate_q + GATE_W'(1);
          end
        end
      end
      S_CELL: begin
        if (last_step) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          step_d  = step_q + STEP_W'(1);
          gate_d  = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any handshake or step transition taken above.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
    if (state_d == S_IDLE) begin
      addr_d = '0;
      gate_d = '0;
      step_d = '0;
    end
  end

  always_comb begin
    valid_d = (state_d == S_ISSUE);
    tanh_d  = valid_d && TANH_EN && (gate_d == TANH_IDX);
    cell_d  = (state_d == S_CELL);
    rec_d   = cell_d && (step_d == '0);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign mvm_valid_o   = valid_q;
  assign mvm_isTanh_o  = tanh_q;
  assign weight_addr_o = addr_q;
  assign gate_idx_o    = gate_q;
  assign step_idx_o    = step_q;
  assign cell_update_o = cell_q;
  assign rec_start_o   = rec_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_clink_mvm_seq.sv
// Directed bench for clink_mvm_seq: per-cycle strobe timeline plus a queue of
// expected MVM requests checked on every valid&ready handshake.
module tb_clink_mvm_seq;
  localparam int NG = 4;
  localparam int AW = 5;
  localparam int SW = 3;
  localparam int GW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_i;
  logic [SW-1:0] num_steps_i;
  logic [AW-1:0] weight_base_i;
  logic          abort_i;
  logic          mvm_ready_i;
  logic          mvm_valid_o;
  logic          mvm_isTanh_o;
  logic [AW-1:0] weight_addr_o;
  logic [GW-1:0] gate_idx_o;
  logic [SW-1:0] step_idx_o;
  logic          cell_update_o;
  logic          rec_start_o;
  logic          busy_o;
  logic          done_o;

  clink_mvm_seq dut (
    .clock         (clock),
    .reset         (reset),
    .start_i       (start_i),
    .num_steps_i   (num_steps_i),
    .weight_base_i (weight_base_i),
    .abort_i       (abort_i),
    .mvm_ready_i   (mvm_ready_i),
    .mvm_valid_o   (mvm_valid_o),
    .mvm_isTanh_o  (mvm_isTanh_o),
    .weight_addr_o (weight_addr_o),
    .gate_idx_o    (gate_idx_o),
    .step_idx_o    (step_idx_o),
    .cell_update_o (cell_update_o),
    .rec_start_o   (rec_start_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [GW-1:0] gate;
    logic [SW-1:0] step;
    logic          tanh;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_outputs();
    return {mvm_valid_o, mvm_isTanh_o, weight_addr_o, gate_idx_o, step_idx_o,
            cell_update_o, rec_start_o, busy_o, done_o};
  endfunction

  // Expected {valid, cell_update, rec_start, done, busy} at cycle c of a run
  // started at cycle 0, with ready low for st_l cycles starting at st_c.
  function automatic logic [4:0] exp_flags(input int c, input int steps,
                                           input int st_c, input int st_l);
    int   e;
    logic v, cl, r, d, b;
    e = c;
    if (st_l > 0 && c >= st_c && c < st_c + st_l) return 5'b10001;
    if (st_l > 0 && c >= st_c + st_l) e = c - st_l;
    v  = (e >= 1) && (e <= steps * (NG + 1)) && (e % (NG + 1) != 0);
    cl = (e >= NG + 1) && (e <= steps * (NG + 1)) && (e % (NG + 1) == 0);
    r  = (e == NG + 1);
    d  = (e == steps * (NG + 1) + 1);
    b  = (e >= 1) && (e <= steps * (NG + 1) + 1);
    return {v, cl, r, d, b};
  endfunction

  task automatic push_run(input int base, input int steps, input int n_txn);
    int n;
    n = 0;
    for (int s = 0; s < steps; s++) begin
      for (int g = 0; g < NG; g++) begin
        txn_t t;
        if (n < n_txn) begin
          t.addr = AW'(base + s * NG + g);
          t.gate = GW'(g);
          t.step = SW'(s);
          t.tanh = (g == 1);
          exp_q.push_back(t);
          n++;
        end
      end
    end
  endtask

  task automatic tick();
    if (mvm_valid_o && mvm_ready_i) begin
      chk("hs_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        txn_t e;
        e = exp_q.pop_front();
        chk("hs_addr", 32'(weight_addr_o), 32'(e.addr));
        chk("hs_gate", 32'(gate_idx_o), 32'(e.gate));
        chk("hs_step", 32'(step_idx_o), 32'(e.step));
        chk("hs_tanh", 32'(mvm_isTanh_o), 32'(e.tanh));
      end
    end
    @(posedge clock);
    #1;
  endtask

  // One run starting now (cycle 0). Negative st_c / ab_c / xs_c disable
  // the stall window, the abort and the extra ignored start respectively.
  task automatic run(input int base, input int steps, input int st_c, input int st_l,
                     input int ab_c, input int xs_c);
    int         last;
    int         n_txn;
    logic [4:0] fl;
    logic       in_stall;
    n_txn = steps * NG;
    if (ab_c >= 0) begin
      n_txn = 0;
      for (int c = 0; c < ab_c; c++) begin
        fl = exp_flags(c, steps, st_c, st_l);
        if (fl[4] && !(st_l > 0 && c >= st_c && c < st_c + st_l)) n_txn++;
      end
    end
    push_run(base, steps, n_txn);
    last = (ab_c >= 0) ? ab_c + 1 : steps * (NG + 1) + 2 + st_l;
    for (int c = 0; c <= last; c++) begin
      in_stall = (st_l > 0) && (c >= st_c) && (c < st_c + st_l);
      start_i  = (c == 0) || (c == xs_c);
      if (c == 0) begin
        num_steps_i   = SW'(steps);
        weight_base_i = AW'(base);
      end
      if (c == xs_c) begin
        num_steps_i   = SW'(1);
        weight_base_i = AW'(17);
      end
      abort_i     = (c == ab_c);
      mvm_ready_i = !(c == ab_c) && !in_stall;
      if (ab_c >= 0 && c > ab_c) begin
        chk($sformatf("flags_after_abort@%0d", c),
            32'({mvm_valid_o, cell_update_o, rec_start_o, done_o, busy_o}), 32'd0);
      end else begin
        chk($sformatf("flags@%0d", c),
            32'({mvm_valid_o, cell_update_o, rec_start_o, done_o, busy_o}),
            32'(exp_flags(c, steps, st_c, st_l)));
      end
      if (in_stall && exp_q.size() != 0) begin
        chk($sformatf("stall_addr@%0d", c), 32'(weight_addr_o), 32'(exp_q[0].addr));
        chk($sformatf("stall_gate@%0d", c), 32'(gate_idx_o), 32'(exp_q[0].gate));
      end
      if (c == last) chk($sformatf("idle_outputs@%0d", c), 32'(all_outputs()), 32'd0);
      tick();
    end
    start_i     = 1'b0;
    abort_i     = 1'b0;
    mvm_ready_i = 1'b1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    start_i       = 1'b0;
    num_steps_i   = '0;
    weight_base_i = '0;
    abort_i       = 1'b0;
    mvm_ready_i   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 32'(all_outputs()), 32'd0);
    reset = 1'b0;
    tick();

    // nominal run, backpressure, address wrap
    run(0, 5, -1, 0, -1, -1);
    run(0, 5, 3, 3, -1, -1);
    run(30, 2, -1, 0, -1, -1);

    // abort at step 1 gate 2, then a fresh run two cycles after the abort
    run(0, 5, -1, 0, 8, -1);
    run(0, 3, -1, 0, -1, -1);

    // start pulsed mid-run must not disturb the sequence
    run(0, 5, -1, 0, -1, 10);

    // start with zero steps is ignored
    start_i     = 1'b1;
    num_steps_i = '0;
    tick();
    start_i = 1'b0;
    chk("zero_steps_idle", 32'(all_outputs()), 32'd0);
    tick();
    chk("zero_steps_busy", 32'(busy_o), 32'd0);

    // start together with abort in IDLE is ignored
    start_i     = 1'b1;
    num_steps_i = SW'(3);
    abort_i     = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("start_abort_idle", 32'(all_outputs()), 32'd0);
    tick();
    chk("start_abort_busy", 32'(busy_o), 32'd0);

    // synchronous reset while stalled in ISSUE
    push_run(0, 5, 2);
    start_i       = 1'b1;
    num_steps_i   = SW'(5);
    weight_base_i = '0;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    mvm_ready_i = 1'b0;
    chk("pre_reset_busy", 32'(busy_o), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    mvm_ready_i = 1'b1;
    chk("midrun_reset_outputs", 32'(all_outputs()), 32'd0);
    chk("midrun_reset_queue", 32'(exp_q.size()), 32'd0);
    tick();
    run(0, 5, -1, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
